// File: rtl/bscan_user_dr_if.sv
// Signal bundle between the BSCANE2 USER port / fabric consumer and the USER data register.
// master drives the raw TAP signals and the capture word; slave is the data register itself.
interface bscan_user_dr_if #(
    parameter int DR_WIDTH = 32,
    parameter int COUNT_W  = 8
);
    logic                tck;
    logic                tdi;
    logic                tdo;
    logic                sel;
    logic                capture;
    logic                shift;
    logic                update;
    logic                test_logic_reset;
    logic [DR_WIDTH-1:0] capture_data;
    logic [DR_WIDTH-1:0] update_data;
    logic                update_valid;
    logic [COUNT_W-1:0]  shift_count;
    logic                length_err;

    modport master (
        output tck, tdi, sel, capture, shift, update, test_logic_reset, capture_data,
        input  tdo, update_data, update_valid, shift_count, length_err
    );

    modport slave (
        input  tck, tdi, sel, capture, shift, update, test_logic_reset, capture_data,
        output tdo, update_data, update_valid, shift_count, length_err
    );
endinterface

// File: rtl/bscan_user_dr.sv
// USER data register behind BSCANE2: oversamples the raw TAP signals in clk and performs
// capture/shift/update of a DR_WIDTH-bit register, returning TDO and a one-cycle update pulse.
module bscan_user_dr #(
    parameter int DR_WIDTH    = 32,
    parameter int SYNC_STAGES = 2,
    parameter int COUNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    bscan_user_dr_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, LOADED, SHIFTING} state_t;

    localparam int NIN = 7;

    logic [NIN-1:0]      raw;
    logic [NIN-1:0]      sync_p [SYNC_STAGES];
    logic                tck_s, tdi_s, sel_s, capture_s, shift_s, update_s, tlr_s;
    logic                tck_prev;
    logic                rise, fall;
    state_t              state, state_nxt;
    logic                do_capture, do_shift, do_update;
    logic [DR_WIDTH-1:0] sr;
    logic [DR_WIDTH-1:0] update_data;
    logic [COUNT_W-1:0]  shift_count;
    logic                update_valid;
    logic                length_err;
    logic                tdo;

    assign raw = {bus.tck, bus.tdi, bus.sel, bus.capture, bus.shift, bus.update,
                  bus.test_logic_reset};

    // Synchronizer chains: all seven TAP inputs share the same depth so they stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
            tck_prev <= 1'b0;
        end else begin
            sync_p[0] <= raw;
            for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
            tck_prev <= tck_s;
        end
    end

    assign {tck_s, tdi_s, sel_s, capture_s, shift_s, update_s, tlr_s} = sync_p[SYNC_STAGES-1];
    assign rise = tck_s & ~tck_prev;
    assign fall = ~tck_s & tck_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (tlr_s)           state_nxt = IDLE;
        else if (do_capture) state_nxt = LOADED;
        else if (do_shift)   state_nxt = SHIFTING;
        else if (do_update)  state_nxt = IDLE;
    end

    // Test-Logic-Reset is a level that blocks every TCK-rise action.
    always_comb begin
        do_capture = 1'b0;
        do_shift   = 1'b0;
        do_update  = 1'b0;
        if (!tlr_s && rise && sel_s) begin
            if (capture_s)                         do_capture = 1'b1;
            else if (shift_s && state != IDLE)     do_shift   = 1'b1;
            else if (update_s && state != IDLE)    do_update  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr           <= '0;
            shift_count  <= '0;
            update_data  <= '0;
            update_valid <= 1'b0;
            length_err   <= 1'b0;
            tdo          <= 1'b0;
        end else begin
            update_valid <= do_update;
            if (fall) tdo <= sr[0];
            if (tlr_s) begin
                shift_count <= '0;
            end else if (do_capture) begin
                sr          <= bus.capture_data;
                shift_count <= '0;
            end else if (do_shift) begin
                sr <= {tdi_s, sr[DR_WIDTH-1:1]};
                if (shift_count != '1) shift_count <= shift_count + COUNT_W'(1);
            end else if (do_update) begin
                update_data <= sr;
                length_err  <= (shift_count != COUNT_W'(DR_WIDTH));
            end
        end
    end

    assign bus.tdo          = tdo;
    assign bus.update_data  = update_data;
    assign bus.update_valid = update_valid;
    assign bus.shift_count  = shift_count;
    assign bus.length_err   = length_err;
endmodule

// File: tb/tb_bscan_user_dr.sv
// Directed bench for bscan_user_dr: drives JTAG-style TCK cycles and compares the DUT
// against a transaction-level model, plus hand-computed literal expectations.
module tb_bscan_user_dr;
    localparam int DW   = 32;
    localparam int CW   = 8;
    localparam int SS   = 2;
    localparam int HALF = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bscan_user_dr_if #(.DR_WIDTH(DW), .COUNT_W(CW)) bus ();

    bscan_user_dr #(.DR_WIDTH(DW), .SYNC_STAGES(SS), .COUNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Transaction-level model state
    logic [DW-1:0] m_sr, m_upd, cap_word;
    bit            m_armed, m_err, m_tdo;
    int            m_cnt, m_pulses, dut_pulses;
    bit            settled, prev_uv, last_tdo;
    int            n_checks, n_pass;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic void model_reset();
        m_sr = '0; m_upd = '0; m_armed = 0; m_err = 0; m_tdo = 0; m_cnt = 0;
    endfunction

    function automatic void model_rise(bit c, bit s, bit u, bit d, bit sl);
        if (!sl) return;
        if (c) begin
            m_sr = cap_word; m_cnt = 0; m_armed = 1;
        end else if (s && m_armed) begin
            m_sr  = (m_sr >> 1) | (DW'(d) << (DW - 1));
            m_cnt = (m_cnt < (1 << CW) - 1) ? m_cnt + 1 : m_cnt;
        end else if (u && m_armed) begin
            m_upd = m_sr; m_err = (m_cnt != DW); m_pulses++; m_armed = 0;
        end
    endfunction

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (bus.update_valid) begin
                dut_pulses++;
                chk("uv_single_cycle", 64'(prev_uv), 64'd0);
            end
            prev_uv = bus.update_valid;
            if (settled) begin
                chk("tdo", 64'(bus.tdo), 64'(m_tdo));
                chk("update_data", 64'(bus.update_data), 64'(m_upd));
                chk("shift_count", 64'(bus.shift_count), 64'(m_cnt));
                chk("length_err", 64'(bus.length_err), 64'(m_err));
                chk("pulse_count", 64'(dut_pulses), 64'(m_pulses));
            end
        end else begin
            prev_uv = 0;
        end
    end

    task automatic wait_half();
        repeat (HALF - 1) @(negedge clk);
        settled = 1;
        @(negedge clk);
        settled = 0;
    endtask

    task automatic tck_cycle(input bit c, input bit s, input bit u, input bit d, input bit sl);
        bus.capture = c; bus.shift = s; bus.update = u; bus.tdi = d; bus.sel = sl;
        wait_half();
        last_tdo = bus.tdo;
        bus.tck = 1'b1;
        model_rise(c, s, u, d, sl);
        wait_half();
        bus.tck = 1'b0;
        m_tdo = m_sr[0];
    endtask

    task automatic idle_tail();
        bus.capture = 0; bus.shift = 0; bus.update = 0; bus.tdi = 0;
        wait_half();
        wait_half();
    endtask

    task automatic run_seq(input logic [DW-1:0] cap, input int nbits, input logic [63:0] din,
                           input bit sl, output logic [DW-1:0] stream);
        stream = '0;
        cap_word = cap;
        bus.capture_data = cap;
        tck_cycle(1, 0, 0, 0, sl);
        for (int i = 0; i < nbits; i++) begin
            tck_cycle(0, 1, 0, din[i], sl);
            if (i < DW) stream[i] = last_tdo;
        end
        tck_cycle(0, 0, 1, 0, sl);
        idle_tail();
    endtask

    logic [DW-1:0] stream;
    int            p0;

    initial begin
        n_checks = 0; n_pass = 0; m_pulses = 0; dut_pulses = 0; settled = 0; prev_uv = 0;
        bus.tck = 0; bus.tdi = 0; bus.sel = 0; bus.capture = 0; bus.shift = 0;
        bus.update = 0; bus.test_logic_reset = 0; bus.capture_data = '0; cap_word = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_tdo", 64'(bus.tdo), 64'd0);
        chk("rst_update_data", 64'(bus.update_data), 64'd0);
        chk("rst_update_valid", 64'(bus.update_valid), 64'd0);
        chk("rst_shift_count", 64'(bus.shift_count), 64'd0);
        chk("rst_length_err", 64'(bus.length_err), 64'd0);
        rst_n = 1'b1;
        wait_half();

        // Nominal read/write
        p0 = dut_pulses;
        run_seq(32'hA5A51234, 32, 64'hDEADBEEF, 1, stream);
        chk("nom_tdo_stream", 64'(stream), 64'hA5A51234);
        chk("nom_update_data", 64'(bus.update_data), 64'hDEADBEEF);
        chk("nom_length_err", 64'(bus.length_err), 64'd0);
        chk("nom_shift_count", 64'(bus.shift_count), 64'd32);
        chk("nom_pulses", 64'(dut_pulses - p0), 64'd1);

        // Short shift
        run_seq(32'hA5A51234, 8, 64'hFF, 1, stream);
        chk("short_update_data", 64'(bus.update_data), 64'hFFA5A512);
        chk("short_shift_count", 64'(bus.shift_count), 64'd8);
        chk("short_length_err", 64'(bus.length_err), 64'd1);

        // sel low: whole sequence ignored
        p0 = dut_pulses;
        run_seq(32'h0BADF00D, 32, 64'h12345678, 0, stream);
        chk("sel0_pulses", 64'(dut_pulses - p0), 64'd0);
        chk("sel0_update_data", 64'(bus.update_data), 64'hFFA5A512);
        chk("sel0_shift_count", 64'(bus.shift_count), 64'd8);

        // Overshift: 0x11 first, then 0xCAFEF00D as the last 32 bits
        run_seq(32'hA5A51234, 40, 64'h00_CAFEF00D_11, 1, stream);
        chk("over_update_data", 64'(bus.update_data), 64'hCAFEF00D);
        chk("over_shift_count", 64'(bus.shift_count), 64'd40);
        chk("over_length_err", 64'(bus.length_err), 64'd1);

        // TLR abort after 10 shift bits, then update without capture
        p0 = dut_pulses;
        cap_word = 32'h5A5A5A5A;
        bus.capture_data = cap_word;
        tck_cycle(1, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) tck_cycle(0, 1, 0, 1'b1, 1);
        bus.shift = 0;
        bus.test_logic_reset = 1'b1;
        m_armed = 0; m_cnt = 0;
        wait_half();
        bus.test_logic_reset = 1'b0;
        wait_half();
        tck_cycle(0, 0, 1, 0, 1);
        idle_tail();
        chk("tlr_pulses", 64'(dut_pulses - p0), 64'd0);
        chk("tlr_shift_count", 64'(bus.shift_count), 64'd0);
        chk("tlr_update_data", 64'(bus.update_data), 64'hCAFEF00D);

        // Async reset mid-shift
        cap_word = 32'hA5A51234;
        bus.capture_data = cap_word;
        tck_cycle(1, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) tck_cycle(0, 1, 0, 1'b1, 1);
        bus.shift = 0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_tdo", 64'(bus.tdo), 64'd0);
        chk("arst_update_data", 64'(bus.update_data), 64'd0);
        chk("arst_update_valid", 64'(bus.update_valid), 64'd0);
        chk("arst_shift_count", 64'(bus.shift_count), 64'd0);
        chk("arst_length_err", 64'(bus.length_err), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_half();

        // Nominal again after reset
        p0 = dut_pulses;
        run_seq(32'hA5A51234, 32, 64'hDEADBEEF, 1, stream);
        chk("post_tdo_stream", 64'(stream), 64'hA5A51234);
        chk("post_update_data", 64'(bus.update_data), 64'hDEADBEEF);
        chk("post_length_err", 64'(bus.length_err), 64'd0);
        chk("post_pulses", 64'(dut_pulses - p0), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/bscan_user_dr.md
Name: bscan_user_dr

Overview:
- Fabric-side USER data register behind the BSCANE2 primitive; replaces the TDI-to-TDO loopback.
- Oversamples the raw JTAG and TAP-state signals in a fast fabric clock, the same clock the debug ILA uses.
- Performs capture, shift and update of a DR_WIDTH-bit register.
- Drives TDO back to the primitive and hands updated words to fabric logic as a one-cycle valid pulse.

Parameters:
- DR_WIDTH, 32: data register length in bits; shifted LSB first.
- SYNC_STAGES, 2: flip-flop synchronizer depth on every JTAG input; minimum 2.
- COUNT_W, 8: width of the shift-bit counter; the counter saturates at all-ones.

Ports:
- clk  in  1  fabric sampling clock; must run at 4x TCK or faster.
- rst_n  in  1  asynchronous active-low reset.
- tck  in  1  raw JTAG TCK from BSCANE2.
- tdi  in  1  raw TDI.
- tdo  out  1  serial data to BSCANE2 TDO.
- sel  in  1  IR holds USER(JTAG_CHAIN).
- capture  in  1  TAP in Capture-DR.
- shift  in  1  TAP in Shift-DR.
- update  in  1  TAP in Update-DR.
- test_logic_reset  in  1  TAP in Test-Logic-Reset.
- capture_data  in  DR_WIDTH  parallel word loaded at Capture-DR; fabric-synchronous.
- update_data  out  DR_WIDTH  word latched at Update-DR.
- update_valid  out  1  one-clk pulse when update_data changes.
- shift_count  out  COUNT_W  bits shifted since the last capture.
- length_err  out  1  last update had shift_count != DR_WIDTH.

Behaviour:
- Reset:
  - Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
  - rst_n low asynchronously clears: tdo, update_data, update_valid, shift_count, length_err, the shift register sr, all synchronizer flops and the TCK history flop. State returns to IDLE.
  - Deassertion is assumed synchronized externally.
- Input synchronization:
  - tck, tdi, sel, capture, shift, update and test_logic_reset each pass through SYNC_STAGES flops.
  - tck_prev holds the previous synchronized tck.
  - rise = tck_s & ~tck_prev; fall = ~tck_s & tck_prev.
  - All decisions use synchronized values only. Input-to-action latency is SYNC_STAGES+1 clk.
- States: IDLE, LOADED, SHIFTING.
- On rise with sel_s=1, evaluate in this priority order (the TAP guarantees exclusivity; the priority only makes behaviour deterministic):
  - capture_s: sr <= capture_data; shift_count <= 0; go to LOADED (from any state).
  - shift_s, in LOADED or SHIFTING: sr <= {tdi_s, sr[DR_WIDTH-1:1]}; shift_count increments, saturating at 2^COUNT_W-1; go to SHIFTING.
  - shift_s in IDLE: ignored.
  - update_s, in LOADED or SHIFTING:
    - update_data <= sr; update_valid=1 for exactly one clk.
    - length_err <= (shift_count != DR_WIDTH).
    - Go to IDLE.
  - update_s in IDLE: ignored, no pulse.
- TDO:
  - On every fall event, tdo <= sr[0]; at all other times tdo holds.
  - The first bit of a capture is therefore presented before the first shift rise, as JTAG requires.
  - tdo is not gated by sel; the TAP muxes it.
- sel_s=0: rise events are ignored. sr, state and counter hold.
- test_logic_reset_s=1 (level, checked every clk, overriding rise actions): state <= IDLE; shift_count <= 0. update_data, length_err and sr hold; no pulse.
- Overshift beyond DR_WIDTH:
  - sr keeps the last DR_WIDTH bits shifted in.
  - Shift-in continues without error; the mismatch is reported only through length_err at update.
- Outputs:
  - update_data and length_err are stable between update pulses.
  - shift_count is readable at any time.

Test Plan:
- Nominal read/write:
  - Stimulus: capture_data=0xA5A51234; capture, shift 32 bits of TDI=0xDEADBEEF LSB first, update.
  - Response: sampled tdo stream = 0xA5A51234 LSB first; exactly one update_valid pulse; update_data=0xDEADBEEF; length_err=0; shift_count=32.
- Short shift:
  - Stimulus: capture 0xA5A51234, shift 8 bits of 0xFF, update.
  - Response: update_data=0xFFA5A512; shift_count=8; length_err=1.
- Overshift:
  - Stimulus: capture, shift 40 bits (0x00000000_11 then 0xCAFEF00D as the last 32), update.
  - Response: update_data=0xCAFEF00D; shift_count=40; length_err=1.
- sel low:
  - Stimulus: full capture/shift/update sequence with sel=0.
  - Response: no update_valid; update_data keeps its prior value; shift_count unchanged.
- TLR abort:
  - Stimulus: test_logic_reset pulsed after 10 shift bits, then update without capture.
  - Response: no pulse; shift_count=0; update_data unchanged.
- Async reset:
  - Stimulus: rst_n low mid-shift (between clk edges).
  - Response: tdo, update_data, update_valid, shift_count and length_err are all 0 before the next clk edge.
  - Follow-up: a subsequent nominal sequence passes.
